// File: rtl/half_adder_db_pkg.sv
// Package: half_adder_db_pkg
// Purpose : Shared constants and types for the registered half adder.
//   CNT_W_DEF - default width of the statistics counters
//   ha_res_t  - packed {sum, carry} result of one half-add
// Optional statistics counters are enabled with macro HALF_ADDER_DB_STATS_EN.
package half_adder_db_pkg;

  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_res_t;

endpackage

// File: rtl/half_adder_db_if.sv
// Interface: half_adder_db_if
// Purpose  : Operand/result bundle between a driver and half_adder_db.
//   A, B, in_valid, clr      driver -> adder
//   S, C, out_valid          adder  -> driver
//   op_cnt, carry_cnt        adder  -> driver (only with HALF_ADDER_DB_STATS_EN)
// Modports: master (driver side), slave (adder side).
interface half_adder_db_if
  import half_adder_db_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic A;
  logic B;
  logic in_valid;
  logic clr;
  logic S;
  logic C;
  logic out_valid;

`ifdef HALF_ADDER_DB_STATS_EN
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output A, B, in_valid, clr,
    input  S, C, out_valid, op_cnt, carry_cnt
  );

  modport slave (
    input  A, B, in_valid, clr,
    output S, C, out_valid, op_cnt, carry_cnt
  );
`else
  // Keeps the width parameter referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;

  modport master (
    output A, B, in_valid, clr,
    input  S, C, out_valid
  );

  modport slave (
    input  A, B, in_valid, clr,
    output S, C, out_valid
  );
`endif

endinterface

// File: rtl/half_adder_db_core.sv
// Module : half_adder_db_core
// Purpose: Purely combinational half-adder cell.
//   a, b : addend bits (in)
//   res  : {sum = a ^ b, carry = a & b} (out)
module half_adder_db_core
  import half_adder_db_pkg::*;
(
  input  logic    a,
  input  logic    b,
  output ha_res_t res
);

  always_comb begin
    res       = '0;
    res.sum   = a ^ b;
    res.carry = a & b;
  end

endmodule

// File: rtl/half_adder_db.sv
// Module : half_adder_db
// Purpose: Registered half adder with one-cycle latency and optional
//          saturating statistics counters.
// Ports  :
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - half_adder_db_if.slave: A, B, in_valid, clr in; S, C, out_valid
//           out; op_cnt, carry_cnt out when HALF_ADDER_DB_STATS_EN is defined.
// Macro  : HALF_ADDER_DB_STATS_EN compiles in op_cnt/carry_cnt and clr.
module half_adder_db
  import half_adder_db_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
)
(
  input  logic             clk,
  input  logic             rst_n,
  half_adder_db_if.slave   bus
);

  ha_res_t core_res;
  ha_res_t res_d, res_q;
  logic    vld_d, vld_q;

  half_adder_db_core u_core (
    .a   (bus.A),
    .b   (bus.B),
    .res (core_res)
  );

  // Result holds its last value on idle cycles; valid is a one-cycle delay.
  always_comb begin
    res_d = res_q;
    vld_d = bus.in_valid;
    if (bus.in_valid) begin
      res_d = core_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign bus.S         = res_q.sum;
  assign bus.C         = res_q.carry;
  assign bus.out_valid = vld_q;

`ifdef HALF_ADDER_DB_STATS_EN
  logic [CNT_W-1:0] op_cnt_d, op_cnt_q;
  logic [CNT_W-1:0] carry_cnt_d, carry_cnt_q;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // clr wins over a same-cycle increment.
  always_comb begin
    op_cnt_d    = op_cnt_q;
    carry_cnt_d = carry_cnt_q;
    if (bus.clr) begin
      op_cnt_d    = '0;
      carry_cnt_d = '0;
    end else if (bus.in_valid) begin
      op_cnt_d = sat_inc(op_cnt_q);
      if (core_res.carry) begin
        carry_cnt_d = sat_inc(carry_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign bus.op_cnt    = op_cnt_q;
  assign bus.carry_cnt = carry_cnt_q;
`else
  // clr has no effect without the counters.
  logic [CNT_W-1:0] unused_clr;
  assign unused_clr = {CNT_W{bus.clr}};
`endif

endmodule

// File: tb/tb_half_adder_db.sv
// Testbench: tb_half_adder_db
// Purpose  : Randomized and directed checks of half_adder_db against a
//            behavioural model. Counter checks are compiled only when
//            HALF_ADDER_DB_STATS_EN is defined.
module tb_half_adder_db;
  import half_adder_db_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst_n;

  half_adder_db_if #(.CNT_W(TB_CNT_W)) bus_if ();

  half_adder_db #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Behavioural model state
  int m_s, m_c, m_v;
  int m_op, m_carry;

  task automatic model_reset();
    m_s = 0; m_c = 0; m_v = 0; m_op = 0; m_carry = 0;
  endtask

  // Drive one cycle of stimulus, advance through the rising edge, update
  // the model and return #1 after the edge for sampling.
  task automatic step(input int a, input int b, input int v, input int cl);
    int total;
    bus_if.A        = a[0];
    bus_if.B        = b[0];
    bus_if.in_valid = v[0];
    bus_if.clr      = cl[0];
    @(posedge clk);
    total = a + b;
    if (rst_n) begin
      if (v != 0) begin
        m_s = total % 2;
        m_c = total / 2;
      end
      m_v = v;
      if (cl != 0) begin
        m_op = 0; m_carry = 0;
      end else if (v != 0) begin
        m_op = (m_op < CNT_MAX) ? m_op + 1 : CNT_MAX;
        if (total == 2) m_carry = (m_carry < CNT_MAX) ? m_carry + 1 : CNT_MAX;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    // Operands offered during reset must be discarded.
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    chk_cnt++;
    if ({bus_if.S, bus_if.C, bus_if.out_valid} !== 3'b000) begin
      $display("FAIL reset_outputs: got S/C/V=%b%b%b expected 000",
               bus_if.S, bus_if.C, bus_if.out_valid);
    end else pass_cnt++;
`ifdef HALF_ADDER_DB_STATS_EN
    chk_cnt++;
    if (bus_if.op_cnt !== 0 || bus_if.carry_cnt !== 0) begin
      $display("FAIL reset_counters: got op=%0d carry=%0d expected 0/0",
               bus_if.op_cnt, bus_if.carry_cnt);
    end else pass_cnt++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [2:0] exp_tab [4];
    exp_tab[0] = 3'b001; exp_tab[1] = 3'b101;
    exp_tab[2] = 3'b101; exp_tab[3] = 3'b011;
    for (int i = 0; i < 4; i++) begin
      step(i / 2, i % 2, 1, 0);
      chk_cnt++;
      if ({bus_if.S, bus_if.C, bus_if.out_valid} !== exp_tab[i]) begin
        $display("FAIL truth_table[%0d%0d]: got S/C/V=%b%b%b expected %b",
                 i / 2, i % 2, bus_if.S, bus_if.C, bus_if.out_valid, exp_tab[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    step(1, 1, 1, 0);
    chk_cnt++;
    if ({bus_if.S, bus_if.C, bus_if.out_valid} !== 3'b011) begin
      $display("FAIL hold_first: got S/C/V=%b%b%b expected 011",
               bus_if.S, bus_if.C, bus_if.out_valid);
    end else pass_cnt++;
    step(0, 0, 0, 0);
    chk_cnt++;
    if ({bus_if.S, bus_if.C, bus_if.out_valid} !== 3'b010) begin
      $display("FAIL hold_idle: got S/C/V=%b%b%b expected 010",
               bus_if.S, bus_if.C, bus_if.out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    int a, b, v, cl, errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      a  = int'($urandom_range(0, 1));
      b  = int'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cl = ($urandom_range(0, 15) == 0) ? 1 : 0;
      step(a, b, v, cl);
      chk_cnt++;
      if (bus_if.S !== m_s[0] || bus_if.C !== m_c[0] || bus_if.out_valid !== m_v[0]) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_result[%0d]: got S/C/V=%b%b%b expected %0d%0d%0d",
                   i, bus_if.S, bus_if.C, bus_if.out_valid, m_s, m_c, m_v);
      end else pass_cnt++;
`ifdef HALF_ADDER_DB_STATS_EN
      chk_cnt++;
      if (int'(bus_if.op_cnt) != m_op || int'(bus_if.carry_cnt) != m_carry) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_counters[%0d]: got op=%0d carry=%0d expected %0d/%0d",
                   i, bus_if.op_cnt, bus_if.carry_cnt, m_op, m_carry);
      end else pass_cnt++;
`endif
    end
  endtask

`ifdef HALF_ADDER_DB_STATS_EN
  task automatic test_saturate();
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0);
    chk_cnt++;
    if (bus_if.op_cnt !== 4'd15 || bus_if.carry_cnt !== 4'd15) begin
      $display("FAIL saturate: got op=%0d carry=%0d expected 15/15",
               bus_if.op_cnt, bus_if.carry_cnt);
    end else pass_cnt++;
  endtask

  task automatic test_clr();
    step(0, 1, 1, 0);
    step(1, 1, 1, 1);
    chk_cnt++;
    if (bus_if.op_cnt !== 4'd0 || bus_if.carry_cnt !== 4'd0) begin
      $display("FAIL clr_counters: got op=%0d carry=%0d expected 0/0",
               bus_if.op_cnt, bus_if.carry_cnt);
    end else pass_cnt++;
    chk_cnt++;
    if ({bus_if.S, bus_if.C, bus_if.out_valid} !== 3'b011) begin
      $display("FAIL clr_result: got S/C/V=%b%b%b expected 011",
               bus_if.S, bus_if.C, bus_if.out_valid);
    end else pass_cnt++;
  endtask
`endif

  task automatic test_async_reset();
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    // Mid-cycle, between edges.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_cnt++;
    if ({bus_if.S, bus_if.C, bus_if.out_valid} !== 3'b000) begin
      $display("FAIL async_reset_outputs: got S/C/V=%b%b%b expected 000",
               bus_if.S, bus_if.C, bus_if.out_valid);
    end else pass_cnt++;
`ifdef HALF_ADDER_DB_STATS_EN
    chk_cnt++;
    if (bus_if.op_cnt !== 0 || bus_if.carry_cnt !== 0) begin
      $display("FAIL async_reset_counters: got op=%0d carry=%0d expected 0/0",
               bus_if.op_cnt, bus_if.carry_cnt);
    end else pass_cnt++;
`endif
    step(1, 1, 1, 0);
    rst_n = 1'b1;
    step(1, 0, 1, 0);
    chk_cnt++;
    if ({bus_if.S, bus_if.C, bus_if.out_valid} !== 3'b101) begin
      $display("FAIL post_reset_first: got S/C/V=%b%b%b expected 101",
               bus_if.S, bus_if.C, bus_if.out_valid);
    end else pass_cnt++;
`ifdef HALF_ADDER_DB_STATS_EN
    chk_cnt++;
    if (bus_if.op_cnt !== 4'd1 || bus_if.carry_cnt !== 4'd0) begin
      $display("FAIL post_reset_counters: got op=%0d carry=%0d expected 1/0",
               bus_if.op_cnt, bus_if.carry_cnt);
    end else pass_cnt++;
`endif
    step(0, 0, 0, 0);
    chk_cnt++;
    if (bus_if.out_valid !== 1'b0) begin
      $display("FAIL post_reset_idle: got out_valid=%b expected 0", bus_if.out_valid);
    end else pass_cnt++;
  endtask

  initial begin
    bus_if.A = 1'b0; bus_if.B = 1'b0; bus_if.in_valid = 1'b0; bus_if.clr = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_random();
`ifdef HALF_ADDER_DB_STATS_EN
    test_saturate();
    test_clr();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
